// File: rtl/serial_sub_mux.sv
// Bit-serial LSB-first subtractor (a - b) built from mux-lookup half-subtractors,
// behind a start/busy/done handshake. Optional macro SERIAL_SUB_SIGNED_EN adds signed overflow.
module serial_sub_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // Handshake: start is honoured only in IDLE or DONE. busy marks SHIFT.
  // done pulses for one cycle with diff/borrow/ovf valid. Results hold until the next done.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Truth tables indexed by {y,x}: bit n holds the output for select value n.
  localparam logic [3:0] DIFF_T   = 4'b0110;
  localparam logic [3:0] BORROW_T = 4'b0100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, rd;
  logic             bq;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             d1, b1, d, b2, bout;
  logic             last_bit;

  function automatic logic mux4(input logic [1:0] sel, input logic [3:0] data);
    return data[sel];
  endfunction

  always_comb begin
    d1   = mux4({rb[0], ra[0]}, DIFF_T);
    b1   = mux4({rb[0], ra[0]}, BORROW_T);
    d    = mux4({bq, d1}, DIFF_T);
    b2   = mux4({bq, d1}, BORROW_T);
    bout = b1 | b2;
  end

  assign load     = start && (state == IDLE || state == DONE);
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      bq     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        ra  <= a;
        rb  <= b;
        bq  <= 1'b0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        rd  <= {d, rd[WIDTH-1:1]};
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        bq  <= bout;
        cnt <= cnt + CW'(1);
      end
      // The final bit is folded in directly so the outputs are valid on DONE entry.
      if (last_bit) begin
        diff   <= {d, rd[WIDTH-1:1]};
        borrow <= bout;
      end
    end
  end

`ifdef SERIAL_SUB_SIGNED_EN
  logic sa, sb, ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= 1'b0;
      sb    <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (load) begin
        sa <= a[WIDTH-1];
        sb <= b[WIDTH-1];
      end
      // d is the MSB of the final difference on the last shift cycle.
      if (last_bit) ovf_r <= (sa ^ sb) & (sa ^ d);
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_mux.sv
// Scoreboard bench for serial_sub_mux (WIDTH=8): directed vectors push expected
// results and done-cycles; a negedge monitor pops and compares on each done pulse.
module tb_serial_sub_mux;

  localparam int W = 8;

`ifdef SERIAL_SUB_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks;
  int errors;
  int edges;

  // Expected word is {diff, borrow, ovf}; cycle queue holds the negedge edge-count of done.
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  serial_sub_mux #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow),
    .ovf   (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) begin
        checks++;
        errors++;
        $display("FAIL busy_and_done: both high at edge %0d", edges);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with empty queue at edge %0d, diff=0x%0h", edges, diff);
        end else begin
          logic [W+1:0] e;
          int           c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("diff",       32'(diff),   32'(e[W+1:2]));
          chk("borrow",     32'(borrow), 32'(e[1]));
          chk("ovf",        32'(ovf),    32'(e[0]));
          chk("done_cycle", 32'(edges),  32'(c));
        end
      end
    end
  end

  // Drivers
  task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic ov_signed, input int cyc);
    exp_q.push_back({d, bo, ov_signed & SIGNED_EN});
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // Single operation: start accepted at the next posedge; done expected W cycles later.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    push_exp(ed, eb, eo, edges + W);
    chk("busy_after_start", 32'(busy), 32'd1);
    repeat (W - 1) @(negedge clk);
    chk("busy_last_shift", 32'(busy), 32'd1);
    wait_drain(4 * W);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_done",   32'(done),   32'd0);
    chk("reset_diff",   32'(diff),   32'd0);
    chk("reset_borrow", 32'(borrow), 32'd0);
    chk("reset_ovf",    32'(ovf),    32'd0);

    foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo);

    // Result holds in IDLE after done.
    repeat (3) @(negedge clk);
    chk("hold_diff",   32'(diff),   32'h87);
    chk("hold_borrow", 32'(borrow), 32'd0);

    // Start during SHIFT is ignored, operand changes have no effect.
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    push_exp(8'h0F, 1'b0, 1'b0, edges + W);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", 32'(busy), 32'd1);
    wait_drain(4 * W);
    repeat (2 * W) @(negedge clk);
    chk("hold_after_ignored", 32'(diff), 32'h0F);

    // Reset mid-operation discards the partial result.
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    chk("midrst_diff",   32'(diff),   32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    repeat (2 * W) @(negedge clk);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: start held high through DONE.
    start = 1'b1;
    a     = 8'h09;
    b     = 8'h03;
    @(negedge clk);
    push_exp(8'h06, 1'b0, 1'b0, edges + W);
    push_exp(8'hFA, 1'b1, 1'b0, edges + 2 * W + 1);
    a = 8'h03;
    b = 8'h09;
    repeat (W + 1) @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_second", 32'(busy), 32'd1);
    wait_drain(4 * W);
    repeat (W) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
